my_serial_cmp: RTL and testbench

Bit-serial unsigned magnitude comparator for two WIDTH-bit operands. It sits directly downstream of the team's single-bit equality cell `my_eq` and consumes its per-bit result one bit per clock, MSB first. After a start/busy/done handshake it produces three results: word equality, a greater-than flag, and the index of the most-significant mismatching bit.

---
 rtl/my_cmp_pkg.sv | 21 ++
 rtl/my_eq.sv | 19 +
 rtl/my_serial_cmp.sv | 181 ++++++++++++++++++
 tb/tb_my_serial_cmp.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_cmp_pkg
// Description : Shared definitions for the bit-serial magnitude comparator:
//               FSM state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package my_cmp_pkg;

  // Default operand width for my_serial_cmp
  localparam int DEFAULT_WIDTH = 8;

  // Comparator FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

endpackage : my_cmp_pkg
`default_nettype wire

// File: rtl/my_eq.sv
`default_nettype none
// ============================================================================
// Module      : my_eq
// Description : Single-bit equality cell. Purely combinational.
// Ports       : a  - input bit A
//               b  - input bit B
//               eq - 1 when a == b
// Revision    : 1.0 - initial release
// ============================================================================
module my_eq (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = ~(a ^ b);

endmodule : my_eq
`default_nettype wire

// File: rtl/my_serial_cmp.sv
`default_nettype none
// ============================================================================
// Module      : my_serial_cmp
// Description : Bit-serial unsigned magnitude comparator. Operands are
//               captured on an accepted start and examined one bit per clock,
//               MSB first, through a single my_eq cell. Reports equality,
//               a > b, and the index of the most-significant mismatching bit.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               start   - request a comparison (sampled in IDLE and DONE)
//               a, b    - WIDTH-bit operands, captured on the accepted start
//               busy    - high while bits are being evaluated (SHIFT)
//               done    - one-cycle pulse, results valid from this cycle on
//               eq      - a == b
//               gt      - a > b (unsigned)
//               mis_idx - index of the MSB-most mismatch, 0 when eq
// Config      : MY_SERIAL_CMP_EARLY_EXIT_EN - when defined, SHIFT ends at the
//               first mismatch instead of always walking all WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module my_serial_cmp
  import my_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic [IDX_W-1:0] mis_idx
);

  cmp_state_t       r_state;
  cmp_state_t       w_state_nxt;
  logic             w_load;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [IDX_W-1:0] r_cnt;
  logic             r_eq_acc;
  logic             r_gt_acc;
  logic             r_found;
  logic             r_eq;
  logic             r_gt;
  logic [IDX_W-1:0] r_mis_idx;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_bit_eq;
  logic             w_first_mis;
  logic             w_last;
  logic             w_exit;
  logic             w_eq_fin;
  logic             w_gt_fin;

  assign w_a_bit = r_a_sh[r_cnt];
  assign w_b_bit = r_b_sh[r_cnt];

  my_eq u_my_eq (
    .a  (w_a_bit),
    .b  (w_b_bit),
    .eq (w_bit_eq)
  );

  // Only the first mismatch seen in SHIFT decides the result
  assign w_first_mis = (r_state == SHIFT) && !w_bit_eq && !r_found;
  assign w_last      = (r_cnt == '0);

`ifdef MY_SERIAL_CMP_EARLY_EXIT_EN
  assign w_exit = w_last || w_first_mis;
`else
  assign w_exit = w_last;
`endif

  // Final accumulator values including the bit evaluated this cycle, so the
  // result registers are already valid in the cycle that done is high.
  assign w_eq_fin = w_first_mis ? 1'b0    : r_eq_acc;
  assign w_gt_fin = w_first_mis ? w_a_bit : r_gt_acc;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // A start seen in DONE is taken on the edge that leaves DONE, which gives
  // the WIDTH+1 cycle back-to-back issue interval.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_exit) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_cnt     <= '0;
      r_eq_acc  <= 1'b0;
      r_gt_acc  <= 1'b0;
      r_found   <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_mis_idx <= '0;
    end else if (w_load) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_cnt    <= IDX_W'(WIDTH - 1);
      r_eq_acc <= 1'b1;
      r_gt_acc <= 1'b0;
      r_found  <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (w_first_mis) begin
        r_eq_acc  <= 1'b0;
        r_gt_acc  <= w_a_bit;
        r_mis_idx <= r_cnt;
        r_found   <= 1'b1;
      end else if (w_exit && r_eq_acc) begin
        // Equal operands: drop any index left from an earlier comparison
        r_mis_idx <= '0;
      end
      if (!w_last) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_exit) begin
        r_eq <= w_eq_fin;
        r_gt <= w_gt_fin;
      end
    end
  end

  assign eq      = r_eq;
  assign gt      = r_gt;
  assign mis_idx = r_mis_idx;

endmodule : my_serial_cmp
`default_nettype wire

// File: tb/tb_my_serial_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_serial_cmp
// Description : Self-checking bench for my_serial_cmp (WIDTH = 8). Expected
//               results come from a word-level reference model: integer
//               compare for eq/gt, top set bit of a^b for mis_idx, and the
//               latency rule of the selected configuration.
// Config      : MY_SERIAL_CMP_EARLY_EXIT_EN - selects expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_serial_cmp;

  localparam int W  = 8;
  localparam int IW = 3;
`ifdef MY_SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic [IW-1:0] mis_idx;

  int n_cmp = 0;
  int n_err = 0;

  my_serial_cmp #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .eq      (eq),
    .gt      (gt),
    .mis_idx (mis_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level reference model
  function automatic void ref_cmp(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  output logic e, output logic g,
                                  output logic [IW-1:0] idx, output int lat);
    logic [W-1:0] x;
    e   = (ra == rb);
    g   = (ra > rb);
    idx = '0;
    x   = ra ^ rb;
    for (int i = 0; i < W; i++) if (x[i]) idx = IW'(i);
    lat = (EARLY && !e) ? (W - int'(idx)) : W;
  endfunction

  // Counts edges after the current point until done is seen (bounded)
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (done !== 1'b1 && cycles < W + 3);
  endtask

  // Runs one comparison from IDLE; operand inputs are scrambled right after
  // the accept edge. Returns observations only.
  task automatic run_cmp(input logic [W-1:0] va, input logic [W-1:0] vb,
                         output logic o_busy0, output int cycles,
                         output logic o_eq, output logic o_gt,
                         output logic [IW-1:0] o_idx, output logic o_done_after);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    o_busy0 = busy;
    a = W'($urandom); b = W'($urandom);
    wait_done(cycles);
    o_eq = eq; o_gt = gt; o_idx = mis_idx;
    @(posedge clk); #1;
    o_done_after = done | busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, eq, gt, mis_idx} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b eq=%b gt=%b idx=%0d, want all 0",
               busy, done, eq, gt, mis_idx);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{8'hA5, 8'h80, 8'h12, 8'h00};
    logic [W-1:0] vb [4] = '{8'hA5, 8'h7F, 8'h13, 8'h00};
    logic ob, oe, og, od, ee, eg;
    logic [IW-1:0] oi, ei;
    int cyc, lat;
    for (int k = 0; k < 4; k++) begin
      ref_cmp(va[k], vb[k], ee, eg, ei, lat);
      run_cmp(va[k], vb[k], ob, cyc, oe, og, oi, od);
      n_cmp++;
      if (ob !== 1'b1 || cyc != lat || od !== 1'b0) begin
        n_err++;
        $display("FAIL dir_timing[%0d]: busy0=%b latency=%0d after=%b, want 1 %0d 0",
                 k, ob, cyc, od, lat);
      end
      n_cmp++;
      if (oe !== ee || og !== eg || oi !== ei) begin
        n_err++;
        $display("FAIL dir_result[%0d] a=%h b=%h: got eq=%b gt=%b idx=%0d, want %b %b %0d",
                 k, va[k], vb[k], oe, og, oi, ee, eg, ei);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic ob, oe, og, od, ee, eg;
    logic [IW-1:0] oi, ei;
    int cyc, lat;
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      ref_cmp(ra, rb, ee, eg, ei, lat);
      run_cmp(ra, rb, ob, cyc, oe, og, oi, od);
      n_cmp++;
      if (ob !== 1'b1 || cyc != lat || od !== 1'b0 || oe !== ee || og !== eg || oi !== ei) begin
        n_err++;
        $display("FAIL rand[%0d] a=%h b=%h: busy0=%b lat=%0d after=%b eq=%b gt=%b idx=%0d, want 1 %0d 0 %b %b %0d",
                 k, ra, rb, ob, cyc, od, oe, og, oi, lat, ee, eg, ei);
      end
    end
  endtask

  // start held high through SHIFT with a new operand on the bus
  task automatic test_start_held();
    logic ee, eg;
    logic [IW-1:0] ei;
    int cyc, lat;
    @(negedge clk);
    a = 8'h3C; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF;
    ref_cmp(8'h3C, 8'h00, ee, eg, ei, lat);
    wait_done(cyc);
    n_cmp++;
    if (cyc != lat || eq !== ee || gt !== eg || mis_idx !== ei) begin
      n_err++;
      $display("FAIL held_first: lat=%0d eq=%b gt=%b idx=%0d, want %0d %b %b %0d",
               cyc, eq, gt, mis_idx, lat, ee, eg, ei);
    end
    // Edge leaving DONE takes the still-asserted start with a=0xFF
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL held_reaccept: busy=%b done=%b, want 1 0", busy, done);
    end
    ref_cmp(8'hFF, 8'h00, ee, eg, ei, lat);
    wait_done(cyc);
    n_cmp++;
    if (cyc != lat || eq !== ee || gt !== eg || mis_idx !== ei) begin
      n_err++;
      $display("FAIL held_second: lat=%0d eq=%b gt=%b idx=%0d, want %0d %b %b %0d",
               cyc, eq, gt, mis_idx, lat, ee, eg, ei);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic ob, oe, og, od;
    logic [IW-1:0] oi;
    int cyc;
    // Leave gt=1, mis_idx=7 registered beforehand
    run_cmp(8'h80, 8'h7F, ob, cyc, oe, og, oi, od);
    @(negedge clk);
    a = 8'h01; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, eq, gt, mis_idx} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b done=%b eq=%b gt=%b idx=%0d, want all 0",
               busy, done, eq, gt, mis_idx);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_cmp(8'h01, 8'h02, ob, cyc, oe, og, oi, od);
    n_cmp++;
    if (ob !== 1'b1 || cyc != W || oe !== 1'b0 || og !== 1'b0 || oi !== 3'd1) begin
      n_err++;
      $display("FAIL post_reset: busy0=%b lat=%0d eq=%b gt=%b idx=%0d, want 1 %0d 0 0 1",
               ob, cyc, oe, og, oi, W);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic ee, eg;
    logic [IW-1:0] ei;
    int cyc, lat;
    for (int k = 0; k < 4; k++) begin
      pa[k] = W'($urandom);
      pb[k] = (k == 1) ? pa[k] : W'($urandom);
    end
    @(negedge clk);
    a = pa[0]; b = pb[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_accept[%0d]: busy=%b, want 1", k, busy);
        end
      end
      if (k < 3) begin
        a = pa[k + 1]; b = pb[k + 1];
      end else begin
        start = 1'b0;
      end
      ref_cmp(pa[k], pb[k], ee, eg, ei, lat);
      wait_done(cyc);
      n_cmp++;
      if (cyc != lat || eq !== ee || gt !== eg || mis_idx !== ei) begin
        n_err++;
        $display("FAIL b2b[%0d] a=%h b=%h: lat=%0d eq=%b gt=%b idx=%0d, want %0d %b %b %0d",
                 k, pa[k], pb[k], cyc, eq, gt, mis_idx, lat, ee, eg, ei);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_my_serial_cmp
`default_nettype wire
